// File: rtl/conv_kernel_scheduler.sv
// Per-layer sequencer for conv2d: per kernel, load it into the kernel BRAM, then run one MAC pass
// per input channel. Optional busy-cycle counter enabled by defining SCHED_PERF_CNT_EN.
module conv_kernel_scheduler #(
`ifdef SCHED_PERF_CNT_EN
    parameter int unsigned PCW = 32,
`endif
    parameter int unsigned CW  = 9
) (
    input  logic           clk,
    input  logic           Reset,
    input  logic           start,
    input  logic [CW-1:0]  cfg_channel_size,
    input  logic [CW-1:0]  cfg_kernel_count,
    input  logic           Kernel_BRAM_IDLE,
    input  logic           last_loading_1ker,
    input  logic           last_channel,
    input  logic           mac_done,
    output logic [CW-1:0]  CHANNEL_SIZE,
    output logic           load_BRAM_dina,
    output logic           update_BRAM_doutb,
    output logic           mac_start,
    output logic [CW-1:0]  kernel_idx,
    output logic [CW-1:0]  channel_idx,
    output logic           busy,
    output logic           done,
`ifdef SCHED_PERF_CNT_EN
    output logic [PCW-1:0] busy_cycles,
`endif
    output logic           cfg_err
);

    typedef enum logic [3:0] {
        StReset, StIdle, StLoadReq, StLoadWait, StMacStart,
        StMacWait, StUpdReq, StUpdWait, StNextKer, StDone
    } state_e;

    state_e        state_q;
    logic [CW-1:0] kcount_q;
    logic          last_seen_q;
    logic          upd_wait_q;
    logic          last_eff;
    logic          cfg_zero;

    assign last_eff = last_seen_q | last_channel;
    assign cfg_zero = (cfg_channel_size == '0) || (cfg_kernel_count == '0);

    // Requests are gated by the live idle flag so they can never reach a busy CU.
    assign load_BRAM_dina    = (state_q == StLoadReq) && Kernel_BRAM_IDLE;
    assign update_BRAM_doutb = (state_q == StUpdReq) && Kernel_BRAM_IDLE;

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q      <= StReset;
            kcount_q     <= '0;
            last_seen_q  <= 1'b0;
            upd_wait_q   <= 1'b0;
            CHANNEL_SIZE <= '0;
            mac_start    <= 1'b0;
            kernel_idx   <= '0;
            channel_idx  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            mac_start <= 1'b0;
            done      <= 1'b0;
            case (state_q)
                StReset: state_q <= StIdle;
                StIdle: begin
                    if (start) begin
                        CHANNEL_SIZE <= cfg_channel_size;
                        kcount_q     <= cfg_kernel_count;
                        kernel_idx   <= '0;
                        channel_idx  <= '0;
                        last_seen_q  <= 1'b0;
                        if (cfg_zero) begin
                            cfg_err <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            cfg_err <= 1'b0;
                            busy    <= 1'b1;
                            state_q <= StLoadReq;
                        end
                    end
                end
                StLoadReq: begin
                    if (Kernel_BRAM_IDLE) state_q <= StLoadWait;
                end
                StLoadWait: begin
                    if (last_loading_1ker) begin
                        channel_idx <= '0;
                        mac_start   <= 1'b1;
                        state_q     <= StMacStart;
                    end
                end
                StMacStart: state_q <= StMacWait;
                StMacWait: begin
                    if (mac_done) state_q <= StUpdReq;
                end
                StUpdReq: begin
                    if (Kernel_BRAM_IDLE) begin
                        upd_wait_q <= 1'b0;
                        state_q    <= StUpdWait;
                    end
                end
                StUpdWait: begin
                    // First cycle is skipped so the CU has time to drop its idle flag.
                    upd_wait_q <= 1'b1;
                    if (last_channel) last_seen_q <= 1'b1;
                    if (upd_wait_q && Kernel_BRAM_IDLE) begin
                        if (last_eff) begin
                            last_seen_q <= 1'b0;
                            if (channel_idx != CHANNEL_SIZE - CW'(1)) cfg_err <= 1'b1;
                            state_q <= StNextKer;
                        end else begin
                            channel_idx <= channel_idx + CW'(1);
                            mac_start   <= 1'b1;
                            state_q     <= StMacStart;
                        end
                    end
                end
                StNextKer: begin
                    if (kernel_idx == kcount_q - CW'(1)) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        kernel_idx <= kernel_idx + CW'(1);
                        state_q    <= StLoadReq;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StReset;
            endcase
        end
    end

`ifdef SCHED_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!Reset) begin
            busy_cycles <= '0;
        end else if (state_q == StIdle && start) begin
            busy_cycles <= '0;
        end else if (busy && !(&busy_cycles)) begin
            busy_cycles <= busy_cycles + PCW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_conv_kernel_scheduler.sv
// Scoreboard bench for conv_kernel_scheduler with a behavioural kernel-BRAM CU and MAC array.
module tb_conv_kernel_scheduler;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          Reset, start;
    logic [CW-1:0] cfg_channel_size, cfg_kernel_count;
    logic          Kernel_BRAM_IDLE, last_loading_1ker, last_channel, mac_done;
    logic [CW-1:0] CHANNEL_SIZE, kernel_idx, channel_idx;
    logic          load_BRAM_dina, update_BRAM_doutb, mac_start, busy, done, cfg_err;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]   busy_cycles;
`endif

    always #5 clk = ~clk;

    conv_kernel_scheduler dut (
        .clk               (clk),
        .Reset             (Reset),
        .start             (start),
        .cfg_channel_size  (cfg_channel_size),
        .cfg_kernel_count  (cfg_kernel_count),
        .Kernel_BRAM_IDLE  (Kernel_BRAM_IDLE),
        .last_loading_1ker (last_loading_1ker),
        .last_channel      (last_channel),
        .mac_done          (mac_done),
        .CHANNEL_SIZE      (CHANNEL_SIZE),
        .load_BRAM_dina    (load_BRAM_dina),
        .update_BRAM_doutb (update_BRAM_doutb),
        .mac_start         (mac_start),
        .kernel_idx        (kernel_idx),
        .channel_idx       (channel_idx),
        .busy              (busy),
        .done              (done),
`ifdef SCHED_PERF_CNT_EN
        .busy_cycles       (busy_cycles),
`endif
        .cfg_err           (cfg_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int q_load[$];
    int q_mac[$];
    int q_upd[$];
    int q_done[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event expected none", name);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    always @(negedge clk) begin
        if (Reset) begin
            if (load_BRAM_dina) begin
                check("load_idle", int'(Kernel_BRAM_IDLE), 1);
                if (q_load.size() == 0) fail("load_extra");
                else check("load_kidx", int'(kernel_idx), q_load.pop_front());
            end
            if (update_BRAM_doutb) begin
                check("upd_idle", int'(Kernel_BRAM_IDLE), 1);
                if (q_upd.size() == 0) fail("upd_extra");
                else check("upd_idx", int'({kernel_idx, channel_idx}), q_upd.pop_front());
            end
            if (mac_start) begin
                if (q_mac.size() == 0) fail("mac_extra");
                else check("mac_idx", int'({kernel_idx, channel_idx}), q_mac.pop_front());
            end
            if (done) begin
                check("done_busy_low", int'(busy), 0);
                if (q_done.size() == 0) fail("done_extra");
                else check("done_err_kidx", int'({cfg_err, kernel_idx}), q_done.pop_front());
`ifdef SCHED_PERF_CNT_EN
                check("busy_cycles", int'(busy_cycles), cyc - start_cyc - 1);
`endif
            end
        end
    end

    // Behavioural CU and MAC array, driven just after each rising edge.
    logic cu_busy, hold_busy;
    logic ld_s, up_s, ms_s, rst_s;
    int   ld_cnt, up_cnt, mac_cnt, rd_ch, tb_ch;

    assign Kernel_BRAM_IDLE = !cu_busy && !hold_busy;

    initial begin
        cu_busy = 1'b0; last_loading_1ker = 1'b0; last_channel = 1'b0; mac_done = 1'b0;
        ld_cnt = 0; up_cnt = 0; mac_cnt = 0; rd_ch = 0;
        forever begin
            @(negedge clk);
            ld_s = load_BRAM_dina; up_s = update_BRAM_doutb; ms_s = mac_start; rst_s = Reset;
            @(posedge clk);
            #1;
            last_loading_1ker = 1'b0; last_channel = 1'b0; mac_done = 1'b0;
            if (!rst_s) begin
                cu_busy = 1'b0; ld_cnt = 0; up_cnt = 0; mac_cnt = 0; rd_ch = 0;
            end else begin
                if (ld_s) begin
                    cu_busy = 1'b1; ld_cnt = 3;
                end else if (ld_cnt > 0) begin
                    ld_cnt--;
                    if (ld_cnt == 0) begin cu_busy = 1'b0; last_loading_1ker = 1'b1; rd_ch = 0; end
                end
                if (up_s) begin
                    cu_busy = 1'b1; up_cnt = 2;
                end else if (up_cnt > 0) begin
                    up_cnt--;
                    if (up_cnt == 0) begin
                        cu_busy = 1'b0;
                        if (rd_ch == tb_ch - 1) begin last_channel = 1'b1; rd_ch = 0; end
                        else rd_ch++;
                    end
                end
                if (ms_s) mac_cnt = 4;
                else if (mac_cnt > 0) begin
                    mac_cnt--;
                    if (mac_cnt == 0) mac_done = 1'b1;
                end
            end
        end
    end

    task automatic run(input int k, input int c, input bit hold, input bit restart);
        int t;
        bit err;
        err = (k == 0) || (c == 0);
        if (!err) begin
            for (int ki = 0; ki < k; ki++) begin
                q_load.push_back(ki);
                for (int ci = 0; ci < c; ci++) begin
                    q_mac.push_back(ki * 512 + ci);
                    q_upd.push_back(ki * 512 + ci);
                end
            end
        end
        q_done.push_back(err ? 512 : (k - 1));
        tb_ch = c;
        cfg_channel_size = CW'(c);
        cfg_kernel_count = CW'(k);
        hold_busy = hold;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        if (err) begin
            @(negedge clk);
            check("err_done_next", int'(done), 1);
            check("err_flag", int'(cfg_err), 1);
            check("err_busy", int'(busy), 0);
        end
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("hold_no_load", int'(load_BRAM_dina), 0);
            end
            @(posedge clk);
            #1 hold_busy = 1'b0;
            @(negedge clk);
            check("load_on_idle_return", int'(load_BRAM_dina), 1);
        end
        if (restart) begin
            repeat (5) @(posedge clk);
            #1 start = 1'b1;
            cfg_channel_size = CW'(7);
            @(posedge clk);
            #1 start = 1'b0;
            check("busy_during_restart", int'(busy), 1);
            cfg_channel_size = CW'(c);
        end
        t = 0;
        while (q_done.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (q_done.size() != 0) begin
            fail("done_timeout");
            q_done.delete();
        end
        check("leftover_events", q_load.size() + q_mac.size() + q_upd.size(), 0);
        check("csize_latched", int'(CHANNEL_SIZE), c);
        check("busy_after_done", int'(busy), 0);
        q_load.delete(); q_mac.delete(); q_upd.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, int'({load_BRAM_dina, update_BRAM_doutb, mac_start, busy, done,
                                    cfg_err}), 0);
        check({name, "_idx"}, int'({kernel_idx, channel_idx}), 0);
        check({name, "_csize"}, int'(CHANNEL_SIZE), 0);
    endtask

    initial begin
        int t;
        Reset = 1'b0; start = 1'b0; hold_busy = 1'b0; tb_ch = 1;
        cfg_channel_size = '0; cfg_kernel_count = '0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 Reset = 1'b1;
        @(posedge clk);
        #1;

        run(1, 1, 1'b0, 1'b0);
        run(2, 3, 1'b0, 1'b1);
        run(0, 2, 1'b0, 1'b0);
        run(1, 2, 1'b1, 1'b0);

        // Reset while waiting on the MAC array.
        q_load.push_back(0);
        q_mac.push_back(0);
        tb_ch = 1;
        cfg_channel_size = CW'(1);
        cfg_kernel_count = CW'(1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!mac_start && t < 200);
        if (!mac_start) fail("abort_mac_timeout");
        @(posedge clk);
        #1 Reset = 1'b0;
        @(posedge clk);
        #1 Reset = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        check("abort_leftover", q_load.size() + q_mac.size(), 0);
        q_load.delete(); q_mac.delete(); q_upd.delete(); q_done.delete();
        repeat (8) @(posedge clk);
        #1;

        run(2, 2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1);
    end
endmodule
